// File: rtl/serial_bus_pkg.sv
// ============================================================================
// Module      : serial_bus_pkg
// Description : Shared types and constants for the bit-serial master port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RWAIT = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } sbm_state_t;

    localparam int c_slave_addr_size = 12;
    localparam int c_word_size       = 8;

    // Serial lanes carry the least-significant bit first.
    localparam bit c_lsb_first = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_shift_reg.sv
// ============================================================================
// Module      : serial_shift_reg
// Description : Loadable shift register with serial in/out, used for TX and RX.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_shift_reg
    import serial_bus_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             bit_i,
    output logic             bit_o,
    output logic [WIDTH-1:0] next_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] w_shifted;

    // next_o is the contents after one more shift, so a caller can grab the
    // completed word on the same edge that shifts in its final bit.
    generate
        if (c_lsb_first) begin : g_lsb_first
            assign w_shifted = {bit_i, data_q[WIDTH-1:1]};
            assign bit_o     = data_q[0];
        end else begin : g_msb_first
            assign w_shifted = {data_q[WIDTH-2:0], bit_i};
            assign bit_o     = data_q[WIDTH-1];
        end
    endgenerate

    assign next_o = w_shifted;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_val_i;
        end else if (shift_i) begin
            data_d = w_shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_master_port.sv
// ============================================================================
// Module      : serial_master_port
// Description : Serialises master read/write requests onto 1-bit bus lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_master_port
    import serial_bus_pkg::*;
#(
    parameter int SLAVE_ADDR_SIZE = c_slave_addr_size,
    parameter int WORD_SIZE       = c_word_size,
    parameter int RD_TIMEOUT      = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [SLAVE_ADDR_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]       req_wdata,
    output logic                       rsp_done,
    output logic                       rsp_err,
    output logic [WORD_SIZE-1:0]       rsp_rdata,
    output logic                       tx_address,
    output logic                       tx_data,
    output logic                       master_valid,
    input  logic                       slave_ready,
    input  logic                       rx_data,
    input  logic                       slave_valid,
    output logic                       master_ready,
    output logic                       write_en,
    output logic                       read_en
);

    localparam int c_max_bits = (SLAVE_ADDR_SIZE > WORD_SIZE) ? SLAVE_ADDR_SIZE : WORD_SIZE;
    localparam int c_cnt_w    = (c_max_bits > 1) ? $clog2(c_max_bits) : 1;
    localparam int c_to_w     = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam int c_tx_w     = SLAVE_ADDR_SIZE + WORD_SIZE;

    localparam logic [c_cnt_w-1:0] c_addr_last = c_cnt_w'(SLAVE_ADDR_SIZE - 1);
    localparam logic [c_cnt_w-1:0] c_word_last = c_cnt_w'(WORD_SIZE - 1);
    localparam logic [c_to_w-1:0]  c_to_last   = c_to_w'(RD_TIMEOUT - 1);

    sbm_state_t           state_q;
    logic [c_cnt_w-1:0]   bit_cnt_q;
    logic [c_to_w-1:0]    to_cnt_q;
    logic                 req_ready_q;
    logic                 master_valid_q;
    logic                 master_ready_q;
    logic                 write_en_q;
    logic                 read_en_q;
    logic                 rsp_done_q;
    logic                 rsp_err_q;
    logic [WORD_SIZE-1:0] rsp_rdata_q;

    logic                 w_accept;
    logic                 w_tx_shift;
    logic                 w_rx_shift;
    logic                 w_tx_bit;
    logic [c_tx_w-1:0]    w_tx_next;
    logic                 w_rx_bit;
    logic [WORD_SIZE-1:0] w_rx_next;
    logic                 w_unused;

    assign w_accept   = (state_q == S_IDLE) && req_valid;
    assign w_tx_shift = ((state_q == S_ADDR) || (state_q == S_WDATA)) && slave_ready;
    assign w_rx_shift = ((state_q == S_RWAIT) || (state_q == S_RDATA)) && slave_valid;

    // Address and data share one TX register: data bits follow the address.
    serial_shift_reg #(
        .WIDTH (c_tx_w)
    ) u_tx_sr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_accept),
        .load_val_i ({req_wdata, req_addr}),
        .shift_i    (w_tx_shift),
        .bit_i      (1'b0),
        .bit_o      (w_tx_bit),
        .next_o     (w_tx_next)
    );

    serial_shift_reg #(
        .WIDTH (WORD_SIZE)
    ) u_rx_sr (
        .clk        (clk),
        .reset      (reset),
        .load_i     (w_accept),
        .load_val_i ({WORD_SIZE{1'b0}}),
        .shift_i    (w_rx_shift),
        .bit_i      (rx_data),
        .bit_o      (w_rx_bit),
        .next_o     (w_rx_next)
    );

    assign w_unused = ^{w_tx_next, w_rx_bit};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            bit_cnt_q      <= '0;
            to_cnt_q       <= '0;
            req_ready_q    <= 1'b1;
            master_valid_q <= 1'b0;
            master_ready_q <= 1'b0;
            write_en_q     <= 1'b0;
            read_en_q      <= 1'b0;
            rsp_done_q     <= 1'b0;
            rsp_err_q      <= 1'b0;
            rsp_rdata_q    <= '0;
        end else begin
            rsp_done_q <= 1'b0;
            rsp_err_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        state_q        <= S_ADDR;
                        bit_cnt_q      <= '0;
                        req_ready_q    <= 1'b0;
                        master_valid_q <= 1'b1;
                        write_en_q     <= req_write;
                        read_en_q      <= !req_write;
                    end
                end
                S_ADDR: begin
                    if (slave_ready) begin
                        if (bit_cnt_q == c_addr_last) begin
                            bit_cnt_q <= '0;
                            if (write_en_q) begin
                                state_q <= S_WDATA;
                            end else begin
                                state_q        <= S_RWAIT;
                                master_valid_q <= 1'b0;
                                master_ready_q <= 1'b1;
                                to_cnt_q       <= '0;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + c_cnt_w'(1);
                        end
                    end
                end
                S_WDATA: begin
                    if (slave_ready) begin
                        if (bit_cnt_q == c_word_last) begin
                            state_q        <= S_DONE;
                            master_valid_q <= 1'b0;
                            write_en_q     <= 1'b0;
                            rsp_done_q     <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + c_cnt_w'(1);
                        end
                    end
                end
                S_RWAIT: begin
                    // A bit arriving on the final timeout cycle still wins.
                    if (slave_valid) begin
                        state_q   <= S_RDATA;
                        bit_cnt_q <= c_cnt_w'(1);
                    end else if (to_cnt_q == c_to_last) begin
                        state_q        <= S_DONE;
                        master_ready_q <= 1'b0;
                        read_en_q      <= 1'b0;
                        rsp_done_q     <= 1'b1;
                        rsp_err_q      <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + c_to_w'(1);
                    end
                end
                S_RDATA: begin
                    if (slave_valid) begin
                        if (bit_cnt_q == c_word_last) begin
                            state_q        <= S_DONE;
                            rsp_rdata_q    <= w_rx_next;
                            master_ready_q <= 1'b0;
                            read_en_q      <= 1'b0;
                            rsp_done_q     <= 1'b1;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + c_cnt_w'(1);
                        end
                    end
                end
                S_DONE: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready    = req_ready_q;
    assign master_valid = master_valid_q;
    assign master_ready = master_ready_q;
    assign write_en     = write_en_q;
    assign read_en      = read_en_q;
    assign rsp_done     = rsp_done_q;
    assign rsp_err      = rsp_err_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign tx_address   = (state_q == S_ADDR) && w_tx_bit;
    assign tx_data      = (state_q == S_WDATA) && w_tx_bit;

endmodule

`default_nettype wire

// File: tb/tb_serial_master_port.sv
// ============================================================================
// Module      : tb_serial_master_port
// Description : Directed self-checking bench for serial_master_port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_master_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [11:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_done;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic        tx_address;
    logic        tx_data;
    logic        master_valid;
    logic        slave_ready;
    logic        rx_data;
    logic        slave_valid;
    logic        master_ready;
    logic        write_en;
    logic        read_en;

    int n_checks = 0;
    int n_err    = 0;

    serial_master_port #(
        .SLAVE_ADDR_SIZE (12),
        .WORD_SIZE       (8),
        .RD_TIMEOUT      (64)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_done     (rsp_done),
        .rsp_err      (rsp_err),
        .rsp_rdata    (rsp_rdata),
        .tx_address   (tx_address),
        .tx_data      (tx_data),
        .master_valid (master_valid),
        .slave_ready  (slave_ready),
        .rx_data      (rx_data),
        .slave_valid  (slave_valid),
        .master_ready (master_ready),
        .write_en     (write_en),
        .read_en      (read_en)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write: cycle 0 accept, then bit transfers modelled against a stall mask.
    task automatic do_write(input string tag, input logic [11:0] a, input logic [7:0] d,
                            input logic [31:0] stall, input int exp_done, input bit hold);
        logic [19:0] bits;
        int idx;
        bits = {d, a};
        req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_wdata = d; slave_ready = 1'b1;
        @(negedge clk);
        chk({tag, "-req_ready"}, req_ready, 1);
        tick();
        if (!hold) begin
            req_valid = 1'b0; req_addr = ~a; req_wdata = ~d;
        end
        idx = 0;
        for (int cyc = 1; cyc < exp_done; cyc++) begin
            slave_ready = (cyc < 32) ? !stall[cyc] : 1'b1;
            @(negedge clk);
            chk({tag, "-mvalid"}, master_valid, 1);
            chk({tag, "-write_en"}, write_en, 1);
            chk({tag, "-done_early"}, rsp_done, 0);
            chk({tag, "-tx_address"}, tx_address, (idx < 12) ? bits[idx] : 1'b0);
            chk({tag, "-tx_data"}, tx_data, (idx >= 12 && idx < 20) ? bits[idx] : 1'b0);
            if (slave_ready) idx++;
            tick();
        end
        slave_ready = 1'b1;
        @(negedge clk);
        chk({tag, "-rsp_done"}, rsp_done, 1);
        chk({tag, "-rsp_err"}, rsp_err, 0);
        chk({tag, "-write_en_done"}, write_en, 0);
        chk({tag, "-mvalid_done"}, master_valid, 0);
        tick();
    endtask

    // Read: delay<0 means the slave never answers (timeout path).
    task automatic do_read(input string tag, input logic [11:0] a, input int delay,
                           input logic [7:0] word, input logic [7:0] exp_rdata);
        bit found;
        req_valid = 1'b1; req_write = 1'b0; req_addr = a; slave_ready = 1'b1;
        slave_valid = 1'b0; rx_data = 1'b0;
        @(negedge clk);
        chk({tag, "-req_ready"}, req_ready, 1);
        tick();
        req_valid = 1'b0; req_addr = ~a;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk({tag, "-read_en"}, read_en, 1);
            chk({tag, "-write_en"}, write_en, 0);
            chk({tag, "-mvalid"}, master_valid, 1);
            chk({tag, "-tx_address"}, tx_address, a[i]);
            tick();
        end
        if (delay < 0) begin
            for (int i = 0; i < 64; i++) begin
                @(negedge clk);
                chk({tag, "-mready_wait"}, master_ready, 1);
                chk({tag, "-done_early"}, rsp_done, 0);
                tick();
            end
            @(negedge clk);
            chk({tag, "-rsp_done"}, rsp_done, 1);
            chk({tag, "-rsp_err"}, rsp_err, 1);
            chk({tag, "-rdata_kept"}, rsp_rdata, exp_rdata);
            chk({tag, "-read_en_done"}, read_en, 0);
            chk({tag, "-mready_done"}, master_ready, 0);
            tick();
        end else begin
            for (int i = 0; i < delay; i++) begin
                @(negedge clk);
                chk({tag, "-mready_wait"}, master_ready, 1);
                chk({tag, "-mvalid_wait"}, master_valid, 0);
                chk({tag, "-done_early"}, rsp_done, 0);
                tick();
            end
            for (int b = 0; b < 8; b++) begin
                slave_valid = 1'b1; rx_data = word[b];
                @(negedge clk);
                chk({tag, "-mready_bit"}, master_ready, 1);
                chk({tag, "-read_en_bit"}, read_en, 1);
                chk({tag, "-done_early"}, rsp_done, 0);
                tick();
            end
            slave_valid = 1'b0; rx_data = 1'b0;
            found = 1'b0;
            for (int w = 0; w < 4 && !found; w++) begin
                @(negedge clk);
                if (rsp_done) found = 1'b1;
                else tick();
            end
            chk({tag, "-done_seen"}, found, 1);
            chk({tag, "-rsp_rdata"}, rsp_rdata, exp_rdata);
            chk({tag, "-rsp_err"}, rsp_err, 0);
            chk({tag, "-read_en_done"}, read_en, 0);
            tick();
        end
        @(negedge clk);
        chk({tag, "-read_en_idle"}, read_en, 0);
        chk({tag, "-req_ready_idle"}, req_ready, 1);
        tick();
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        slave_ready = 1'b0; rx_data = 1'b0; slave_valid = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("rst-req_ready", req_ready, 1);
        chk("rst-mvalid", master_valid, 0);
        chk("rst-mready", master_ready, 0);
        chk("rst-write_en", write_en, 0);
        chk("rst-read_en", read_en, 0);
        chk("rst-rsp_done", rsp_done, 0);
        chk("rst-rsp_err", rsp_err, 0);
        chk("rst-rsp_rdata", rsp_rdata, 0);
        chk("rst-tx_address", tx_address, 0);
        chk("rst-tx_data", tx_data, 0);
        reset = 1'b0;
        tick();

        do_write("wr", 12'h5A3, 8'hC7, 32'h0, 21, 1'b0);
        do_write("wr_stall", 12'h5A3, 8'hC7, 32'h0000_8008, 23, 1'b0);
        do_read("rd", 12'h010, 10, 8'h96, 8'h96);
        do_read("rd_to", 12'h3FF, -1, 8'h00, 8'h96);

        // Reset while WDATA is sending bit 4 (cycle 17).
        req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h0F0; req_wdata = 8'h5C;
        slave_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        for (int c = 1; c < 17; c++) tick();
        @(negedge clk);
        chk("mid-tx_data_bit4", tx_data, 1);
        chk("mid-write_en", write_en, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("mid-req_ready", req_ready, 1);
        chk("mid-mvalid", master_valid, 0);
        chk("mid-write_en_rst", write_en, 0);
        chk("mid-rsp_done", rsp_done, 0);
        chk("mid-tx_data", tx_data, 0);
        chk("mid-rsp_rdata", rsp_rdata, 0);
        tick();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid-no_done", rsp_done, 0);
            tick();
        end

        do_write("b2b_1", 12'hA5C, 8'h3E, 32'h0, 21, 1'b1);
        do_write("b2b_2", 12'h123, 8'h81, 32'h0, 21, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
